sort_stream: RTL and testbench



---
 rtl/sort_pkg.sv | 15 +
 rtl/sort_cmp.sv | 18 +
 rtl/sort_stream.sv | 125 ++++++++++++
 tb/tb_sort_stream.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the serial selection sorter.
package sort_pkg;

   typedef enum logic [1:0] {LOAD, SCAN, SWAP, DRAIN} state_e;

   // Edges from the last input accept until out_valid is visible
   function automatic int unsigned sort_cycles(input int unsigned n);
      return n * (n - 1) / 2 + n - 1;
   endfunction

   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sort_cmp.sv
// Candidate-wins compare; SORT_ASCEND_EN selects ascending (strict <) instead of descending (strict >).
module sort_cmp #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] cand,
   input  logic [W-1:0] best,
   output logic         wins
);

   always_comb begin
`ifdef SORT_ASCEND_EN
      wins = (cand < best);
`else
      wins = (cand > best);
`endif
   end

endmodule

// File: rtl/sort_stream.sv
// Serial in-place selection sorter: load N words, sort one compare per clock, drain in order.
// Sort direction is set by SORT_ASCEND_EN inside sort_cmp (descending when undefined).
module sort_stream
   import sort_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         busy
);

   localparam int unsigned IW = idx_width(N);
   localparam logic [IW-1:0] LAST   = IW'(N - 1);
   localparam logic [IW-1:0] PENULT = IW'(N - 2);
   localparam logic [IW-1:0] ONE    = IW'(1);
   localparam logic [IW-1:0] TWO    = IW'(2);

   state_e        state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] i_q, i_d;
   logic [IW-1:0] j_q, j_d;
   logic [IW-1:0] max_q, max_d;
   logic [IW-1:0] k_q, k_d;
   logic [W-1:0]  arr_q [N];
   logic [W-1:0]  arr_d [N];
   logic          cand_wins;

   sort_cmp #(.W(W)) u_cmp (
      .cand (arr_q[j_q]),
      .best (arr_q[max_q]),
      .wins (cand_wins)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      i_d     = i_q;
      j_d     = j_q;
      max_d   = max_q;
      k_d     = k_q;
      arr_d   = arr_q;
      unique case (state_q)
         LOAD: begin
            if (in_valid) begin
               arr_d[cnt_q] = in_data;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  i_d     = '0;
                  j_d     = ONE;
                  max_d   = '0;
                  state_d = SCAN;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
         end
         SCAN: begin
            if (cand_wins) max_d = j_q;
            if (j_q == LAST) state_d = SWAP;
            else             j_d     = j_q + ONE;
         end
         SWAP: begin
            // max_q == i_q degenerates to rewriting the same entry
            arr_d[i_q]   = arr_q[max_q];
            arr_d[max_q] = arr_q[i_q];
            if (i_q == PENULT) begin
               k_d     = '0;
               state_d = DRAIN;
            end else begin
               i_d     = i_q + ONE;
               max_d   = i_q + ONE;
               j_d     = i_q + TWO;
               state_d = SCAN;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (k_q == LAST) begin
                  k_d     = '0;
                  state_d = LOAD;
               end else begin
                  k_d = k_q + ONE;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
         cnt_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
         max_q   <= '0;
         k_q     <= '0;
         for (int unsigned e = 0; e < N; e++) arr_q[e] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         i_q     <= i_d;
         j_q     <= j_d;
         max_q   <= max_d;
         k_q     <= k_d;
         for (int unsigned e = 0; e < N; e++) arr_q[e] <= arr_d[e];
      end
   end

   assign in_ready  = (state_q == LOAD);
   assign out_valid = (state_q == DRAIN);
   assign busy      = (state_q == SCAN) || (state_q == SWAP);
   assign out_data  = arr_q[k_q];
   assign out_last  = (state_q == DRAIN) && (k_q == LAST);

endmodule

// File: tb/tb_sort_stream.sv
// Directed bench for sort_stream (N=8, W=8); expectations flip to ascending under SORT_ASCEND_EN.
module tb_sort_stream;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       busy;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned pc    = 0;

   logic [7:0] vin  [8];
   logic [7:0] vexp [8];

   sort_stream #(.N(8), .W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Packed vectors list element 0 in the top byte; vexp holds the descending order
   task automatic set_vec(input logic [63:0] pin, input logic [63:0] pexp);
      for (int i = 0; i < 8; i++) begin
         vin[i]  = pin[63-8*i -: 8];
         vexp[i] = pexp[63-8*i -: 8];
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_out_last"},  {31'd0, out_last},  32'd0);
      chk({tag, "_busy"},      {31'd0, busy},      32'd0);
      chk({tag, "_out_data"},  {24'd0, out_data},  32'd0);
   endtask

   // Called at a negedge; returns at the negedge after the last accept edge
   task automatic load_batch(input string tag);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = vin[i];
         chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic wait_sorted(input string tag);
      int unsigned cyc = 0;
      int unsigned busy_cnt = 0;
      int unsigned rdy_cnt = 0;
      while (!out_valid && cyc < 200) begin
         if (busy)     busy_cnt++;
         if (in_ready) rdy_cnt++;
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      chk({tag, "_latency"}, cyc, 32'd35);
      chk({tag, "_busy_cycles"}, busy_cnt, 32'd35);
      chk({tag, "_in_ready_high"}, rdy_cnt, 32'd0);
   endtask

   // stall=1 drives out_ready with the repeating pattern 1,0,0
   task automatic drain(input string tag, input logic stall);
      int unsigned idx = 0;
      int unsigned guard = 0;
      int unsigned e;
      pc = 0;
      while (idx < 8 && guard < 200) begin
`ifdef SORT_ASCEND_EN
         e = 7 - idx;
`else
         e = idx;
`endif
         out_ready = stall ? (pc % 3 == 0) : 1'b1;
         pc++;
         chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
         chk({tag, "_out_data"},  {24'd0, out_data},  {24'd0, vexp[e]});
         chk({tag, "_out_last"},  {31'd0, out_last},  {31'd0, (idx == 7)});
         if (out_ready) idx++;
         @(posedge clk);
         @(negedge clk);
         guard++;
      end
      out_ready = 1'b1;
      chk({tag, "_words_delivered"}, idx, 32'd8);
      chk({tag, "_back_to_load"}, {31'd0, in_ready}, 32'd1);
      chk({tag, "_valid_dropped"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      @(negedge clk);
      check_reset_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic distinct values
      set_vec(64'h03_07_01_08_02_06_05_04, 64'h08_07_06_05_04_03_02_01);
      load_batch("b1");
      wait_sorted("b1");
      drain("b1", 1'b0);

      // Ties; garbage on in_valid while sorting must be ignored
      set_vec(64'h05_05_05_00_00_09_09_01, 64'h09_09_05_05_05_01_00_00);
      load_batch("b2");
      in_valid = 1'b1;
      in_data  = 8'hAA;
      wait_sorted("b2");
      in_valid = 1'b0;
      in_data  = 8'h00;
      drain("b2", 1'b0);

      // Unsigned compare around the sign bit
      set_vec(64'hFF_00_80_7F_01_FE_81_7E, 64'hFF_FE_81_80_7F_7E_01_00);
      load_batch("b3");
      wait_sorted("b3");
      drain("b3", 1'b0);

      // Stalled drain, then the next batch starts right after the final handshake
      set_vec(64'h03_07_01_08_02_06_05_04, 64'h08_07_06_05_04_03_02_01);
      load_batch("b4");
      wait_sorted("b4");
      drain("b4", 1'b1);

      // Abort mid-SCAN after ten compares
      load_batch("b5");
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("b5_busy_before_abort", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      @(negedge clk);
      check_reset_outputs("rst_hold");
      rst_n = 1'b1;
      @(negedge clk);
      set_vec(64'h01_02_03_04_05_06_07_08, 64'h08_07_06_05_04_03_02_01);
      load_batch("b6");
      wait_sorted("b6");
      drain("b6", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
